// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared definitions for the APB3 register-file slave:
//   - apb_state_t     : transfer FSM states (IDLE, WAIT, DONE)
//   - APB_STRIDE      : byte distance between consecutive registers
//   - access_error()  : error-decode predicate for one access
//   - wait_cnt_width(): width of the wait-state down-counter (minimum 1)
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_t;

  localparam int APB_STRIDE = 4;

  // An access errors when it is not word aligned, targets a register that
  // does not exist, or tries to write a read-only register.
  function automatic logic access_error(
    input logic [1:0] byte_off,
    input logic       idx_valid,
    input logic       is_write,
    input logic       is_ro
  );
    return (byte_off != 2'b00) || !idx_valid || (is_write && is_ro);
  endfunction

  // A zero-wait-state build still instantiates a 1-bit counter so the
  // port widths never collapse to zero.
  function automatic int wait_cnt_width(input int wait_states);
    return (wait_states > 0) ? $clog2(wait_states + 1) : 1;
  endfunction

endpackage

// File: rtl/apb3_wait_ctr.sv
// apb3_wait_ctr
//   Loadable down-counter that paces the wait states of one APB transfer.
//   Ports:
//     clk      : clock
//     reset    : synchronous, active-high reset (count -> 0)
//     load     : load load_val (has priority over dec)
//     load_val : value loaded on load
//     dec      : decrement by one; saturates at zero
//     zero     : high while the count is zero
module apb3_wait_ctr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - WIDTH'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/apb3_regfile_slave.sv
// apb3_regfile_slave
//   APB3 slave exposing NUM_REGS word-aligned 32-bit registers. Each register
//   is RW (stored here, visible on reg_out) or RO (value taken from reg_in).
//   Every transfer takes WAIT_STATES access cycles with pready low before the
//   completing cycle. Bad addresses, misaligned accesses and writes to RO
//   registers complete with pslverr=1 and have no side effects.
//   Ports:
//     pclk, reset             : clock, synchronous active-high reset
//     psel, penable, pwrite   : APB control
//     paddr, pwdata           : APB byte address, write data
//     prdata, pready, pslverr : APB response (non-zero only in DONE)
//     reg_in                  : hardware values for RO registers
//     reg_out                 : RW register contents (RO slices are 0)
//     wr_strobe, rd_strobe    : per-register pulse on write commit / read
module apb3_regfile_slave
  import apb_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 12,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           pclk,
  input  logic                           reset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_strobe,
  output logic [NUM_REGS-1:0]            rd_strobe
);

  localparam int OFF_W    = $clog2(APB_STRIDE);
  localparam int IDX_W    = ADDR_WIDTH - OFF_W;
  localparam int CNT_W    = wait_cnt_width(WAIT_STATES);
  localparam int LOAD_VAL = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  apb_state_t            state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  wr_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] prdata_reg;
  logic                  pready_reg;
  logic                  pslverr_reg;
  logic [NUM_REGS-1:0]   rd_strobe_reg;

  logic                  setup;
  logic                  in_idle;
  logic [IDX_W-1:0]      paddr_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_wr;
  logic                  sel_err;
  logic                  dec_err;
  logic [NUM_REGS-1:0]   sel_hit;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  go_done;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic                  wr_commit;

  assign setup     = psel && !penable;
  assign in_idle   = (state_reg == IDLE);
  assign paddr_idx = paddr[ADDR_WIDTH-1:OFF_W];

  // With zero wait states the DONE response is captured on the same edge
  // that accepts the setup, so in IDLE the decode must look at the live bus
  // rather than the latched copy.
  assign sel_idx = in_idle ? paddr_idx : idx_reg;
  assign sel_wr  = in_idle ? pwrite    : wr_reg;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
    assign sel_hit[gi] = (sel_idx == IDX_W'(gi));
    assign wr_hit[gi]  = (idx_reg == IDX_W'(gi));
  end

  // No hit bit set means the index is beyond the implemented registers.
  assign dec_err = access_error(paddr[OFF_W-1:0], |sel_hit, pwrite,
                                |(sel_hit & RO_MASK));
  assign sel_err = in_idle ? dec_err : err_reg;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_hit[i]) begin
        rd_mux = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH]
                            : reg_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-step decisions shared by the FSM and the wait counter.
  always_comb begin
    go_done  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (setup) begin
          if (WAIT_STATES == 0) go_done  = 1'b1;
          else                  cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (psel) begin
          if (cnt_zero) go_done = 1'b1;
          else          cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  apb3_wait_ctr #(
    .WIDTH(CNT_W)
  ) u_wait_ctr (
    .clk      (pclk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(LOAD_VAL)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      wr_reg        <= 1'b0;
      err_reg       <= 1'b0;
      wdata_reg     <= '0;
      prdata_reg    <= '0;
      pready_reg    <= 1'b0;
      pslverr_reg   <= 1'b0;
      rd_strobe_reg <= '0;
    end else begin
      // Response outputs are non-zero only for the single DONE cycle.
      pready_reg    <= 1'b0;
      pslverr_reg   <= 1'b0;
      prdata_reg    <= '0;
      rd_strobe_reg <= '0;
      if (go_done) begin
        pready_reg  <= 1'b1;
        pslverr_reg <= sel_err;
        if (!sel_wr && !sel_err) begin
          prdata_reg    <= rd_mux;
          rd_strobe_reg <= sel_hit;
        end
      end

      case (state_reg)
        IDLE: begin
          if (setup) begin
            idx_reg   <= paddr_idx;
            wr_reg    <= pwrite;
            wdata_reg <= pwdata;
            err_reg   <= dec_err;
            state_reg <= (WAIT_STATES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!psel)         state_reg <= IDLE;
          else if (cnt_zero) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A write lands only when the master completes the handshake in DONE.
  assign wr_commit = (state_reg == DONE) && psel && penable && wr_reg && !err_reg;
  assign wr_strobe = wr_commit ? wr_hit : '0;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q_reg;
      always_ff @(posedge pclk) begin
        if (reset) begin
          q_reg <= '0;
        end else if (wr_commit && wr_hit[gi]) begin
          q_reg <= wdata_reg;
        end
      end
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
    end
  end

  assign prdata    = prdata_reg;
  assign pready    = pready_reg;
  assign pslverr   = pslverr_reg;
  assign rd_strobe = rd_strobe_reg;

endmodule

// File: tb/tb_apb3_regfile_slave.sv
// tb_apb3_regfile_slave
//   Three slave instances share one APB bus (separate psel): instance 0 has
//   no wait states, instance 1 three, instance 2 two; all have 8 registers
//   with register 2 read-only. Table-driven transfers go through a
//   scoreboard; hand-written sequences cover abort and reset mid-transfer.
module tb_apb3_regfile_slave;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int NI = 3;
  localparam logic [NR-1:0] RO = 8'h04;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]    psel;
  logic             penable;
  logic             pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [NR*DW-1:0] reg_in;

  logic [DW-1:0]    prdata_a    [NI];
  logic             pready_a    [NI];
  logic             pslverr_a   [NI];
  logic [NR*DW-1:0] reg_out_a   [NI];
  logic [NR-1:0]    wr_strobe_a [NI];
  logic [NR-1:0]    rd_strobe_a [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    apb3_regfile_slave #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .NUM_REGS    (NR),
      .WAIT_STATES (ws_of(gi)),
      .RO_MASK     (RO)
    ) u_dut (
      .pclk      (clk),
      .reset     (reset),
      .psel      (psel[gi]),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata_a[gi]),
      .pready    (pready_a[gi]),
      .pslverr   (pslverr_a[gi]),
      .reg_in    (reg_in),
      .reg_out   (reg_out_a[gi]),
      .wr_strobe (wr_strobe_a[gi]),
      .rd_strobe (rd_strobe_a[gi])
    );
  end

  typedef struct {
    int            k;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    logic [NR-1:0] exp_wstb;
    logic [NR-1:0] exp_rstb;
  } vec_t;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    bit            err;
    logic [NR-1:0] wstb;
    logic [NR-1:0] rstb;
    int            waits;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string what, input int id,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got 0x%08h, expected 0x%08h", what, id, act, exp);
    end
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  // One full transfer; returns at the DONE cycle so a following call
  // issues its setup in the very next cycle.
  task automatic apb_xfer(input vec_t v, input int id);
    exp_t e;
    int   waits;
    bit   done;
    e = '{id, v.exp_rdata, v.exp_err, v.exp_wstb, v.exp_rstb, ws_of(v.k)};
    sb_q.push_back(e);
    @(posedge clk); #1;
    psel       = '0;
    psel[v.k]  = 1'b1;
    penable    = 1'b0;
    pwrite     = v.wr;
    paddr      = v.addr;
    pwdata     = v.wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (pready_a[v.k] === 1'b1) begin
        done = 1'b1;
      end else begin
        check("wait_quiet", id,
              DW'({pslverr_a[v.k], prdata_a[v.k] != '0, rd_strobe_a[v.k], wr_strobe_a[v.k]}), '0);
        waits++;
        @(posedge clk); #1;
      end
    end
    e = sb_q.pop_front();
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL pready_timeout (txn %0d): got pready=0 after 20 cycles, expected pready=1", e.id);
    end else begin
      if (!v.wr) check("prdata", e.id, prdata_a[v.k], e.rdata);
      check("pslverr",   e.id, DW'(pslverr_a[v.k]), DW'(e.err));
      check("wr_strobe", e.id, DW'(wr_strobe_a[v.k]), DW'(e.wstb));
      check("rd_strobe", e.id, DW'(rd_strobe_a[v.k]), DW'(e.rstb));
      check("wait_cycles", e.id, DW'(waits), DW'(e.waits));
    end
    $display("txn %0d: dut%0d %s addr=0x%03h wdata=0x%08h prdata=0x%08h pslverr=%0b waits=%0d",
             e.id, v.k, v.wr ? "WR" : "RD", v.addr, v.wdata, prdata_a[v.k], pslverr_a[v.k], waits);
  endtask

  initial begin
    vec_t v;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = 32'hC0DE_0000 + DW'(i);
    reg_in[2*DW +: DW] = 32'h0000_1234;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("reset_pready",  100 + k, DW'(pready_a[k]),  '0);
      check("reset_pslverr", 100 + k, DW'(pslverr_a[k]), '0);
      check("reset_prdata",  100 + k, prdata_a[k],        '0);
      check("reset_strobes", 100 + k, DW'({wr_strobe_a[k], rd_strobe_a[k]}), '0);
      check("reset_reg_out_lo", 100 + k, reg_out_a[k][DW-1:0], '0);
    end
    reset = 1'b0;

    //            k  wr addr     wdata         exp_rdata     err wstb   rstb
    vecs[0]  = '{0, 1, 12'h004, 32'hDEADBEEF, 32'h00000000, 0, 8'h02, 8'h00};
    vecs[1]  = '{0, 0, 12'h004, 32'h00000000, 32'hDEADBEEF, 0, 8'h00, 8'h02};
    vecs[2]  = '{0, 1, 12'h008, 32'h55555555, 32'h00000000, 1, 8'h00, 8'h00};
    vecs[3]  = '{0, 0, 12'h008, 32'h00000000, 32'h00001234, 0, 8'h00, 8'h04};
    vecs[4]  = '{0, 0, 12'h002, 32'h00000000, 32'h00000000, 1, 8'h00, 8'h00};
    vecs[5]  = '{0, 0, 12'h020, 32'h00000000, 32'h00000000, 1, 8'h00, 8'h00};
    vecs[6]  = '{0, 1, 12'h00C, 32'hA5A5A5A5, 32'h00000000, 0, 8'h08, 8'h00};
    vecs[7]  = '{0, 0, 12'h00C, 32'h00000000, 32'hA5A5A5A5, 0, 8'h00, 8'h08};
    vecs[8]  = '{0, 1, 12'h01F, 32'h77777777, 32'h00000000, 1, 8'h00, 8'h00};
    vecs[9]  = '{0, 0, 12'h01C, 32'h00000000, 32'h00000000, 0, 8'h00, 8'h80};
    vecs[10] = '{1, 0, 12'h000, 32'h00000000, 32'h00000000, 0, 8'h00, 8'h01};
    vecs[11] = '{1, 1, 12'h010, 32'h12345678, 32'h00000000, 0, 8'h10, 8'h00};
    vecs[12] = '{1, 0, 12'h010, 32'h00000000, 32'h12345678, 0, 8'h00, 8'h10};
    vecs[13] = '{1, 0, 12'h008, 32'h00000000, 32'h00001234, 0, 8'h00, 8'h04};

    // Applied back-to-back: each setup follows the previous DONE directly.
    for (int i = 0; i < 14; i++) apb_xfer(vecs[i], i);
    bus_idle();
    #1;

    check("reg_out0_r1",     200, reg_out_a[0][1*DW +: DW], 32'hDEADBEEF);
    check("reg_out0_r2_ro",  201, reg_out_a[0][2*DW +: DW], 32'h00000000);
    check("reg_out0_r3",     202, reg_out_a[0][3*DW +: DW], 32'hA5A5A5A5);
    check("reg_out0_r7",     203, reg_out_a[0][7*DW +: DW], 32'h00000000);
    check("reg_out1_r4",     204, reg_out_a[1][4*DW +: DW], 32'h12345678);
    check("wr_strobe_after", 205, DW'(wr_strobe_a[0]), '0);

    // Abort: psel dropped while instance 1 is waiting on a write.
    @(posedge clk); #1;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h11111111;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    check("abort_wait_pready", 300, DW'(pready_a[1]), '0);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("abort_no_response", 301 + c, DW'({pready_a[1], wr_strobe_a[1]}), '0);
    end
    check("abort_reg_unchanged", 305, reg_out_a[1][1*DW +: DW], 32'h00000000);
    v = '{1, 0, 12'h004, 32'h0, 32'h00000000, 0, 8'h00, 8'h02};
    apb_xfer(v, 306);
    bus_idle();

    // Reset during the WAIT phase of a write on instance 2.
    @(posedge clk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    check("rst_mid_wait_pready", 400, DW'(pready_a[2]), '0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_pready",    401, DW'(pready_a[2]), '0);
    check("rst_mid_wr_strobe", 402, DW'(wr_strobe_a[2]), '0);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_mid_after", 403 + c, DW'({pready_a[2], wr_strobe_a[2]}), '0);
    end
    psel = '0; penable = 1'b0;
    #1;
    check("rst_mid_reg0",      405, reg_out_a[2][0*DW +: DW], 32'h00000000);
    check("rst_clears_dut0_r1", 406, reg_out_a[0][1*DW +: DW], 32'h00000000);
    check("rst_clears_dut1_r4", 407, reg_out_a[1][4*DW +: DW], 32'h00000000);

    // Normal operation resumes after reset.
    v = '{2, 1, 12'h014, 32'hCAFEF00D, 32'h00000000, 0, 8'h20, 8'h00};
    apb_xfer(v, 500);
    v = '{2, 0, 12'h014, 32'h0, 32'hCAFEF00D, 0, 8'h00, 8'h20};
    apb_xfer(v, 501);
    bus_idle();
    #1;
    check("post_rst_reg5", 502, reg_out_a[2][5*DW +: DW], 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
